// File: rtl/mult_share_arbiter_pkg.sv
// Shared definitions for the two-requester multiplier arbiter: state encoding,
// operand/product widths and the round-robin pick rule.
package mult_share_arbiter_pkg;

   localparam int W  = 4;
   localparam int PW = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   // Contention alternates away from the last winner; a lone requester always wins.
   function automatic logic rr_pick(input logic v0, input logic v1, input logic last);
      if (v0 && v1) return ~last;
      return v1;
   endfunction

endpackage

// File: rtl/wallace_multiplier.sv
// 4x4 unsigned multiplier: partial products reduced by two 3:2 carry-save layers,
// then one carry-propagate add.
module wallace_multiplier
   import mult_share_arbiter_pkg::*;
(
   input  logic [W-1:0]  a,
   input  logic [W-1:0]  b,
   output logic [PW-1:0] p
);

   logic [PW-1:0] pp [W];
   logic [PW-1:0] s1, c1, s2, c2;

   always_comb begin
      for (int i = 0; i < W; i++) begin
         pp[i] = b[i] ? (PW'(a) << i) : '0;
      end
      s1 = pp[0] ^ pp[1] ^ pp[2];
      c1 = ((pp[0] & pp[1]) | (pp[0] & pp[2]) | (pp[1] & pp[2])) << 1;
      s2 = s1 ^ c1 ^ pp[3];
      c2 = ((s1 & c1) | (s1 & pp[3]) | (c1 & pp[3])) << 1;
      p  = s2 + c2;
   end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one multiplier between two requesters with round-robin arbitration;
// one operation in flight, result held until the consumer takes it.
module mult_share_arbiter #(
   parameter int W = mult_share_arbiter_pkg::W
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               req0_valid,
   input  logic [W-1:0]                       req0_a,
   input  logic [W-1:0]                       req0_b,
   output logic                               req0_ready,
   input  logic                               req1_valid,
   input  logic [W-1:0]                       req1_a,
   input  logic [W-1:0]                       req1_b,
   output logic                               req1_ready,
   output logic                               rsp_valid,
   output logic                               rsp_id,
   output logic [mult_share_arbiter_pkg::PW-1:0] rsp_product,
   input  logic                               rsp_ready,
   output logic                               busy
);

   import mult_share_arbiter_pkg::*;

   state_e        state_q, state_d;
   logic [W-1:0]  a_q, a_d, b_q, b_d;
   logic          id_q, id_d;
   logic          last_q, last_d;
   logic [PW-1:0] product_q, product_d;
   logic [PW-1:0] mult_p;
   logic          grant_id;
   logic          any_valid;

   assign any_valid = req0_valid | req1_valid;
   assign grant_id  = rr_pick(req0_valid, req1_valid, last_q);

   wallace_multiplier u_mult (
      .a (a_q),
      .b (b_q),
      .p (mult_p)
   );

   // NOTE: non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Pointer resets to 1 so requester 0 wins the first contention.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q       <= '0;
         b_q       <= '0;
         id_q      <= 1'b0;
         last_q    <= 1'b1;
         product_q <= '0;
      end else begin
         a_q       <= a_d;
         b_q       <= b_d;
         id_q      <= id_d;
         last_q    <= last_d;
         product_q <= product_d;
      end
   end

   // NOTE: every variable gets a default first so no path infers a latch.
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      id_d      = id_q;
      last_d    = last_q;
      product_d = product_q;
      case (state_q)
         ST_IDLE: begin
            if (any_valid) begin
               state_d = ST_CALC;
               id_d    = grant_id;
               last_d  = grant_id;
               a_d     = grant_id ? req1_a : req0_a;
               b_d     = grant_id ? req1_b : req0_b;
            end
         end
         ST_CALC: begin
            product_d = mult_p;
            state_d   = ST_DONE;
         end
         ST_DONE: begin
            if (rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Handshake outputs are forced low during the reset cycle.
   always_comb begin
      req0_ready  = 1'b0;
      req1_ready  = 1'b0;
      rsp_valid   = 1'b0;
      busy        = 1'b0;
      rsp_id      = id_q;
      rsp_product = product_q;
      if (!rst) begin
         req0_ready = (state_q == ST_IDLE) && req0_valid && !grant_id;
         req1_ready = (state_q == ST_IDLE) && req1_valid &&  grant_id;
         rsp_valid  = (state_q == ST_DONE);
         busy       = (state_q != ST_IDLE);
      end
   end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench: a transaction-level model of the arbiter checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_mult_share_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0_valid, req1_valid;
   logic [3:0] req0_a, req0_b, req1_a, req1_b;
   logic       req0_ready, req1_ready;
   logic       rsp_valid, rsp_id, rsp_ready, busy;
   logic [7:0] rsp_product;

   always #5 clk = ~clk;

   mult_share_arbiter #(.W(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .req0_valid  (req0_valid),
      .req0_a      (req0_a),
      .req0_b      (req0_b),
      .req0_ready  (req0_ready),
      .req1_valid  (req1_valid),
      .req1_a      (req1_a),
      .req1_b      (req1_b),
      .req1_ready  (req1_ready),
      .rsp_valid   (rsp_valid),
      .rsp_id      (rsp_id),
      .rsp_product (rsp_product),
      .rsp_ready   (rsp_ready),
      .busy        (busy)
   );

   typedef struct {int a; int b;} op_t;
   typedef struct {int id; int prod; int cyc;} ev_t;

   op_t q0[$], q1[$];
   ev_t rsp_log[$], gnt_log[$];

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   logic acc0 = 1'b0, acc1 = 1'b0;
   bit   rand_ready = 1'b0;

   // Model: one pending job, aged in clock edges since its grant.
   bit m_pending = 1'b0;
   int m_age = 0, m_id = 0, m_prod = 0, m_last = 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int pick(input logic v0, input logic v1, input int last);
      if (v0 && v1) return (last == 0) ? 1 : 0;
      if (v0) return 0;
      return 1;
   endfunction

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) begin
         m_pending <= 1'b0;
         m_last    <= 1;
         m_age     <= 0;
      end else if (m_pending) begin
         if (m_age >= 2 && rsp_ready) m_pending <= 1'b0;
         else                         m_age <= m_age + 1;
      end else if (req0_valid || req1_valid) begin
         m_pending <= 1'b1;
         m_age     <= 1;
         m_id      <= pick(req0_valid, req1_valid, m_last);
         m_last    <= pick(req0_valid, req1_valid, m_last);
         if (pick(req0_valid, req1_valid, m_last) == 1) m_prod <= int'(req1_a) * int'(req1_b);
         else                                           m_prod <= int'(req0_a) * int'(req0_b);
      end
   end

   always @(negedge clk) begin
      int   g;
      logic e_valid;
      g       = pick(req0_valid, req1_valid, m_last);
      e_valid = !rst && m_pending && (m_age >= 2);
      check("busy", busy, !rst && m_pending);
      check("rsp_valid", rsp_valid, e_valid);
      check("req0_ready", req0_ready, !rst && !m_pending && req0_valid && (g == 0));
      check("req1_ready", req1_ready, !rst && !m_pending && req1_valid && (g == 1));
      if (e_valid) begin
         check("rsp_id", rsp_id, m_id);
         check("rsp_product", rsp_product, m_prod);
      end
      acc0 = req0_ready;
      acc1 = req1_ready;
      if (req0_ready) gnt_log.push_back('{0, 0, cyc});
      if (req1_ready) gnt_log.push_back('{1, 0, cyc});
      if (rsp_valid && rsp_ready) rsp_log.push_back('{int'(rsp_id), int'(rsp_product), cyc});
   end

   task automatic push0(input int a, input int b);
      q0.push_back('{a, b});
   endtask

   task automatic push1(input int a, input int b);
      q1.push_back('{a, b});
   endtask

   task automatic drive_reqs();
      req0_valid = (q0.size() > 0);
      req1_valid = (q1.size() > 0);
      req0_a = req0_valid ? 4'(q0[0].a) : 4'd0;
      req0_b = req0_valid ? 4'(q0[0].b) : 4'd0;
      req1_a = req1_valid ? 4'(q1[0].a) : 4'd0;
      req1_b = req1_valid ? 4'(q1[0].b) : 4'd0;
   endtask

   // Requesters hold their operands until accepted, then present the next one.
   task automatic step();
      @(posedge clk);
      #1;
      if (acc0 && q0.size() > 0) void'(q0.pop_front());
      if (acc1 && q1.size() > 0) void'(q1.pop_front());
      drive_reqs();
      if (rand_ready) rsp_ready = ($urandom_range(0, 1) == 1);
   endtask

   task automatic do_reset();
      step();
      q0.delete();
      q1.delete();
      drive_reqs();
      rst = 1'b1;
      step();
      rst = 1'b0;
      rsp_log.delete();
      gnt_log.delete();
   endtask

   task automatic run_until_idle(input string name, input int max_cycles);
      bit done = 1'b0;
      for (int i = 0; i < max_cycles && !done; i++) begin
         step();
         @(negedge clk);
         if (q0.size() == 0 && q1.size() == 0 && busy === 1'b0) done = 1'b1;
      end
      check({name, "_drained"}, done, 1);
   endtask

   initial begin
      rst = 1'b1;
      rsp_ready = 1'b1;
      drive_reqs();

      // Reset and first transaction: 4x5.
      step();
      push0(4, 5);
      drive_reqs();
      @(negedge clk);
      check("rst_req0_ready", req0_ready, 0);
      check("rst_busy", busy, 0);
      step();
      rst = 1'b0;
      @(negedge clk);
      check("rst_product", rsp_product, 0);
      check("rst_id", rsp_id, 0);
      check("t1_grant_same_cycle", req0_ready, 1);
      step();
      @(negedge clk);
      check("t1_calc_busy", busy, 1);
      check("t1_calc_no_rsp", rsp_valid, 0);
      step();
      @(negedge clk);
      check("t1_rsp_valid", rsp_valid, 1);
      check("t1_product", rsp_product, 20);
      check("t1_id", rsp_id, 0);
      run_until_idle("t1", 20);

      // Contention with held requests, two rounds.
      do_reset();
      push0(9, 5);
      push1(15, 5);
      drive_reqs();
      run_until_idle("t2a", 30);
      push0(2, 3);
      push1(1, 7);
      run_until_idle("t2b", 30);
      check("t2_count", rsp_log.size(), 4);
      check("t2_r0_id", rsp_log[0].id, 0);
      check("t2_r0_prod", rsp_log[0].prod, 45);
      check("t2_r1_id", rsp_log[1].id, 1);
      check("t2_r1_prod", rsp_log[1].prod, 75);
      check("t2_spacing", rsp_log[1].cyc - rsp_log[0].cyc, 3);
      check("t2_round2_first_id", rsp_log[2].id, 0);
      check("t2_round2_first_prod", rsp_log[2].prod, 6);
      check("t2_round2_second_prod", rsp_log[3].prod, 7);

      // Back-pressure: result held while req1 waits.
      do_reset();
      rsp_ready = 1'b0;
      push0(12, 4);
      push1(7, 6);
      drive_reqs();
      @(negedge clk);
      check("t3_req0_grant", req0_ready, 1);
      check("t3_req1_wait", req1_ready, 0);
      step();
      step();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t3_hold_valid", rsp_valid, 1);
         check("t3_hold_prod", rsp_product, 48);
         check("t3_hold_req1", req1_ready, 0);
         step();
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      check("t3_handshake", rsp_valid, 1);
      step();
      @(negedge clk);
      check("t3_req1_after_idle", req1_ready, 1);
      run_until_idle("t3", 20);
      check("t3_req1_prod", rsp_log[rsp_log.size()-1].prod, 42);

      // Reset while computing discards the job.
      do_reset();
      push0(5, 5);
      drive_reqs();
      @(negedge clk);
      check("t4_grant", req0_ready, 1);
      step();
      rst = 1'b1;
      @(negedge clk);
      check("t4_rst_busy", busy, 0);
      step();
      rst = 1'b0;
      rsp_log.delete();
      push0(6, 2);
      push1(3, 4);
      drive_reqs();
      @(negedge clk);
      check("t4_after_rsp_valid", rsp_valid, 0);
      check("t4_after_busy", busy, 0);
      check("t4_req0_wins", req0_ready, 1);
      check("t4_req1_loses", req1_ready, 0);
      run_until_idle("t4", 30);
      check("t4_count", rsp_log.size(), 2);
      check("t4_first_id", rsp_log[0].id, 0);
      check("t4_first_prod", rsp_log[0].prod, 12);

      // Operand boundaries and work-conserving repeat grant.
      do_reset();
      push0(15, 15);
      push1(0, 0);
      drive_reqs();
      run_until_idle("t5a", 30);
      push1(3, 5);
      run_until_idle("t5b", 30);
      check("t5_max_prod", rsp_log[0].prod, 225);
      check("t5_zero_prod", rsp_log[1].prod, 0);
      check("t5_zero_id", rsp_log[1].id, 1);
      check("t5_repeat_grant_id", gnt_log[2].id, 1);
      check("t5_repeat_prod", rsp_log[2].prod, 15);

      // Mixed traffic with random consumer back-pressure, checked by the model.
      do_reset();
      rand_ready = 1'b1;
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 1) == 1) push1(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
         else                           push0(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      end
      run_until_idle("t6", 600);
      rand_ready = 1'b0;
      rsp_ready  = 1'b1;
      check("t6_count", rsp_log.size(), 30);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
